// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} dmem_arb_state_t;

  localparam int PORT_IF    = 0;
  localparam int PORT_LSU   = 1;
  localparam int ALIGN_BITS = 3;

  function automatic logic is_misaligned(input logic [ALIGN_BITS-1:0] low);
    return |low;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between the two requesters and the memory arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant: the port that did not win last time has priority.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  logic other;

  always_comb begin
    other = ~last_grant;
    grant = 2'b00;
    if (valid[other])
      grant[other] = 1'b1;
    else if (valid[last_grant])
      grant[last_grant] = 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer sharing one single-port data memory between fetch and LSU.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err
);

  localparam int               CNT_W    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  dmem_arb_state_t   state;
  logic [CNT_W-1:0]  cnt;
  logic              last_grant;
  logic              gnt_port;
  logic              we_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [1:0]        grant;
  logic              sel_port;
  logic              sel_we;
  logic              accept;
  logic              misaligned;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_rr (
    .valid      (bus.req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    sel_port   = grant[PORT_LSU];
    accept     = (state == IDLE) && (grant != 2'b00) && !reset;
    sel_addr   = sel_port ? bus.req_addr[PORT_LSU*ADDR_W +: ADDR_W]
                          : bus.req_addr[PORT_IF*ADDR_W +: ADDR_W];
    sel_wdata  = sel_port ? bus.req_wdata[PORT_LSU*DATA_W +: DATA_W]
                          : bus.req_wdata[PORT_IF*DATA_W +: DATA_W];
    sel_we     = bus.req_we[sel_port];
    misaligned = is_misaligned(sel_addr[ALIGN_BITS-1:0]);

    bus.req_ready = accept ? grant : 2'b00;
    bus.rsp_valid = 2'b00;
    if (state == RESP)
      bus.rsp_valid[gnt_port] = 1'b1;
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;

    // Single write pulse on the final ACCESS cycle; reset suppresses it.
    mem_we = (state == ACCESS) && (cnt == '0) && we_q && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      gnt_port   <= 1'b0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= sel_port;
            gnt_port   <= sel_port;
            we_q       <= sel_we;
            // Misaligned requests bypass memory so mem_addr keeps its old value.
            if (misaligned) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              state   <= RESP;
            end else begin
              mem_addr  <= sel_addr;
              mem_wdata <= sel_wdata;
              cnt       <= CNT_INIT;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            rdata_q <= we_q ? '0 : mem_rdata;
            err_q   <= mem_err;
            state   <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready[gnt_port])
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
